// File: rtl/n64_vmux_pkg.sv
// -----------------------------------------------------------------------------
// n64_vmux_pkg
// Shared video-bus definitions for the N64 pixel transmitter (and any receiver
// that decodes the same bus):
//   - default colour / counter widths
//   - bit positions of sync, R, G, B inside a packed pixel word
//   - the IDLE pixel's sync nibble (R=G=B=0), so both ends agree on it
//   - phase encoding of the 4-slot pixel transfer
// -----------------------------------------------------------------------------
package n64_vmux_pkg;

  localparam int COLOR_W_DEF = 7;   // width of one colour component
  localparam int CNT_W_DEF   = 8;   // width of the underrun statistics counter
  localparam int SYNC_W      = 4;   // {nVSYNC, nCLAMP, nHSYNC, nCSYNC}

  // Sync nibble of the IDLE pixel: all syncs inactive (high); colours are zero.
  localparam logic [SYNC_W-1:0] IDLE_SYNC = 4'hF;

  // Blue always sits at the bottom of the pixel word.
  localparam int VD_B_LSB = 0;

  // Pixel word layout, MSB first: {sync, R, G, B}.
  function automatic int pix_w(input int cw);
    return 3 * cw + SYNC_W;
  endfunction

  function automatic int sync_lsb(input int cw);
    return 3 * cw;
  endfunction

  function automatic int r_lsb(input int cw);
    return 2 * cw;
  endfunction

  function automatic int g_lsb(input int cw);
    return cw;
  endfunction

  // The phase is named after what the edge leaving it puts on VD_o.
  typedef enum logic [1:0] {
    PH_R    = 2'd0,
    PH_G    = 2'd1,
    PH_B    = 2'd2,
    PH_SYNC = 2'd3
  } phase_e;

endpackage

// File: rtl/n64_vmux_fifo.sv
// -----------------------------------------------------------------------------
// n64_vmux_fifo
// Two-entry pixel FIFO between the pixel source and the slot scheduler.
// Ports:
//   VCLK      video clock, rising edge
//   nVRST_Tx  asynchronous active-low reset (empties the FIFO)
//   i_push    write i_din (ignored when full)
//   i_pop     drop the head entry (ignored when empty)
//   i_flush   synchronous empty; wins over push and pop
//   i_din     pixel to write
//   o_dout    head entry (valid only while o_count != 0)
//   o_count   number of stored entries, 0..2
// A simultaneous push and pop keeps the count and preserves order, because
// the write goes to the tail slot while the read pointer moves off the head.
// -----------------------------------------------------------------------------
module n64_vmux_fifo #(
  parameter int W = 25
) (
  input  logic         VCLK,
  input  logic         nVRST_Tx,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic         w_push_ok;
  logic         w_pop_ok;

  // NOTE: combinational blocks assign every output before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_push_ok = 1'b0;
    w_pop_ok  = 1'b0;
    if (!i_flush) begin
      w_push_ok = i_push && (r_count != 2'd2);
      w_pop_ok  = i_pop  && (r_count != 2'd0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples pre-edge values, independent of block ordering.
  always_ff @(posedge VCLK or negedge nVRST_Tx) begin
    if (!nVRST_Tx) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop_ok)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are never observed
  // while r_count says the slot is empty, so a reset would only cost area.
  always_ff @(posedge VCLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/n64_vmux.sv
// -----------------------------------------------------------------------------
// n64_vmux
// N64 video-bus transmitter. Pixels arrive on a valid/ready port, are queued
// in a 2-entry FIFO and sent as four VCLK slots each:
//   sync slot : nVDSYNC_o=0, VD_o={0.., sync nibble}
//   R, G, B   : nVDSYNC_o=1, VD_o=colour
// A free-running phase counter defines the slots; a new pixel is taken from the
// FIFO only on the edge that starts a sync slot. An empty FIFO at that edge
// repeats the previous pixel and bumps a saturating underrun counter.
// Ports:
//   VCLK          video clock, rising edge
//   nVRST_Tx      asynchronous active-low reset
//   en            transmitter enable; low flushes the FIFO and sends IDLE
//   clr_stats     synchronous clear of underrun_cnt (beats an increment)
//   in_valid      pixel offered on in_pix
//   in_ready      pixel will be accepted this edge
//   in_pix        {sync[3:0], R, G, B}
//   nVDSYNC_o     low during the sync slot
//   VD_o          multiplexed video data
//   underrun_cnt  saturating count of starved slots
// -----------------------------------------------------------------------------
module n64_vmux
  import n64_vmux_pkg::*;
#(
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     VCLK,
  input  logic                     nVRST_Tx,
  input  logic                     en,
  input  logic                     clr_stats,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3*COLOR_W+4-1:0]   in_pix,
  output logic                     nVDSYNC_o,
  output logic [COLOR_W-1:0]       VD_o,
  output logic [CNT_W-1:0]         underrun_cnt
);

  localparam int PIX_W    = pix_w(COLOR_W);
  localparam int SYNC_LSB = sync_lsb(COLOR_W);
  localparam int R_LSB    = r_lsb(COLOR_W);
  localparam int G_LSB    = g_lsb(COLOR_W);

  localparam logic [PIX_W-1:0] IDLE_PIX = {IDLE_SYNC, {(3 * COLOR_W){1'b0}}};

  // Registered state
  phase_e              r_ph;
  logic [PIX_W-1:0]    r_cur;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_nvdsync;
  logic [COLOR_W-1:0]  r_vd;

  // FIFO interface
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic [PIX_W-1:0]    w_fifo_head;
  logic [1:0]          w_fifo_count;

  // Next-state values
  logic                w_slot_edge;
  logic                w_underrun;
  logic [PIX_W-1:0]    w_cur_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_nvdsync_next;
  logic [COLOR_W-1:0]  w_vd_next;

  // Ready comes only from registered FIFO state (plus en), never from the
  // pop decision, so a pixel pushed at a sync edge waits for the next slot.
  assign in_ready = nVRST_Tx & en & (w_fifo_count < 2'd2);
  assign w_push   = in_valid & in_ready;
  assign w_flush  = ~en;

  n64_vmux_fifo #(
    .W (PIX_W)
  ) u_fifo (
    .VCLK     (VCLK),
    .nVRST_Tx (nVRST_Tx),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (w_flush),
    .i_din    (in_pix),
    .o_dout   (w_fifo_head),
    .o_count  (w_fifo_count)
  );

  // Pixel selection at the start of each sync slot.
  always_comb begin
    w_slot_edge = (r_ph == PH_SYNC);
    w_cur_next  = r_cur;
    w_pop       = 1'b0;
    w_underrun  = 1'b0;
    if (w_slot_edge) begin
      if (!en) begin
        w_cur_next = IDLE_PIX;
      end else if (w_fifo_count != 2'd0) begin
        w_cur_next = w_fifo_head;
        w_pop      = 1'b1;
      end else begin
        w_underrun = 1'b1;
      end
    end
  end

  // Output mux. The sync slot shows the pixel being loaded on this same edge,
  // so it uses w_cur_next; the colour slots read the already-loaded r_cur.
  always_comb begin
    w_nvdsync_next = 1'b1;
    w_vd_next      = '0;
    case (r_ph)
      PH_SYNC: begin
        w_nvdsync_next             = 1'b0;
        w_vd_next[SYNC_W-1:0]      = w_cur_next[SYNC_LSB +: SYNC_W];
      end
      PH_R:    w_vd_next = r_cur[R_LSB    +: COLOR_W];
      PH_G:    w_vd_next = r_cur[G_LSB    +: COLOR_W];
      PH_B:    w_vd_next = r_cur[VD_B_LSB +: COLOR_W];
      default: w_vd_next = '0;
    endcase
  end

  // Saturating underrun counter; clearing beats counting.
  always_comb begin
    w_cnt_next = r_cnt;
    if (clr_stats) begin
      w_cnt_next = '0;
    end else if (w_underrun && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Reset parks the phase on PH_SYNC so the first edge after release starts
  // a fresh pixel (IDLE), and any partially sent pixel is simply dropped.
  always_ff @(posedge VCLK or negedge nVRST_Tx) begin
    if (!nVRST_Tx) begin
      r_ph      <= PH_SYNC;
      r_cur     <= IDLE_PIX;
      r_cnt     <= '0;
      r_nvdsync <= 1'b1;
      r_vd      <= '0;
    end else begin
      r_ph      <= phase_e'(r_ph + 2'd1);
      r_cur     <= w_cur_next;
      r_cnt     <= w_cnt_next;
      r_nvdsync <= w_nvdsync_next;
      r_vd      <= w_vd_next;
    end
  end

  assign nVDSYNC_o    = r_nvdsync;
  assign VD_o         = r_vd;
  assign underrun_cnt = r_cnt;

endmodule
